// File: rtl/pipelined_instruction_decoder.sv
// Pipelined RV32I/RV64I instruction decoder.
// Stage p0 decodes the incoming word combinationally. Stage p1 is a
// two-entry skid buffer (output register + skid register) so the accept
// side never sees a combinational path from out_ready.
module pipelined_instruction_decoder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         Instruction,
  input  logic [ADDR_W-1:0]   Address_mem,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                MW,
  output logic                RW,
  output logic                MD,
  output logic                MB,
  output logic                MP,
  output logic [3:0]          FS,
  output logic [4:0]          RD,
  output logic [4:0]          RS1,
  output logic [4:0]          RS2,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [DATA_W/8-1:0] STRB,
  output logic [DATA_W-1:0]   IMM,
  output logic                illegal
);

  localparam int SB_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(SB_W);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] FS_ADD   = 4'd0;
  localparam logic [3:0] FS_SUB   = 4'd1;
  localparam logic [3:0] FS_SLL   = 4'd2;
  localparam logic [3:0] FS_SLT   = 4'd3;
  localparam logic [3:0] FS_SLTU  = 4'd4;
  localparam logic [3:0] FS_XOR   = 4'd5;
  localparam logic [3:0] FS_SRL   = 4'd6;
  localparam logic [3:0] FS_SRA   = 4'd7;
  localparam logic [3:0] FS_OR    = 4'd8;
  localparam logic [3:0] FS_AND   = 4'd9;
  localparam logic [3:0] FS_PASSB = 4'd10;

  typedef struct packed {
    logic                     illegal;
    logic                     mw;
    logic                     rw;
    logic                     md;
    logic                     mb;
    logic                     mp;
    logic [3:0]               fs;
    logic [4:0]               rd;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [SB_W-1:0]          strb;
    logic signed [DATA_W-1:0] imm;
  } dec_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  // Sign-extend a 32-bit immediate pattern to the datapath width.
  function automatic logic signed [DATA_W-1:0] f_sext32(input logic signed [31:0] v);
    return DATA_W'(v);
  endfunction

  // ALU function for OP / OP-IMM; alt selects SUB/SRA.
  function automatic logic [3:0] f_alu_fs(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? FS_SUB : FS_ADD;
      3'b001:  return FS_SLL;
      3'b010:  return FS_SLT;
      3'b011:  return FS_SLTU;
      3'b100:  return FS_XOR;
      3'b101:  return alt ? FS_SRA : FS_SRL;
      3'b110:  return FS_OR;
      default: return FS_AND;
    endcase
  endfunction

  // Byte-lane strobe for a store of size f3 at byte offset n.
  function automatic logic [SB_W-1:0] f_strb(input logic [2:0] f3, input logic [OFF_W-1:0] n);
    case (f3)
      3'b000:  return SB_W'(1)  << n;
      3'b001:  return SB_W'(3)  << n;
      3'b010:  return SB_W'(15) << n;
      3'b011:  return (DATA_W == 64) ? '1 : '0;
      default: return '0;
    endcase
  endfunction

  // Offset not a multiple of the access size.
  function automatic logic f_misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] n);
    case (f3)
      3'b001:  return n[0];
      3'b010:  return |n[1:0];
      3'b011:  return |n;
      default: return 1'b0;
    endcase
  endfunction

  logic [OFF_W-1:0] w_n;
  logic             w_unused;
  logic             w_accept;
  logic             w_retire;
  logic             w_f3_wide;
  dec_t             w_dec_p0;

  state_t r_state;
  logic   r_vld_p1;
  logic   r_in_ready;
  dec_t   r_out_p1;
  dec_t   r_skid_p1;

  assign w_n       = Address_mem[OFF_W-1:0];
  assign w_unused  = ^Address_mem[ADDR_W-1:OFF_W];
  assign w_f3_wide = (DATA_W == 32) && (Instruction[14:12] == 3'b011);
  assign w_accept  = in_valid & r_in_ready;
  assign w_retire  = r_vld_p1 & out_ready;

  // ---- stage p0: combinational decode of the incoming word ----
  always_comb begin
    w_dec_p0        = '0;
    w_dec_p0.opcode = Instruction[6:0];
    w_dec_p0.rd     = Instruction[11:7];
    w_dec_p0.funct3 = Instruction[14:12];
    w_dec_p0.rs1    = Instruction[19:15];
    w_dec_p0.rs2    = Instruction[24:20];
    case (Instruction[6:0])
      OP_LUI: begin
        w_dec_p0.mb  = 1'b1;
        w_dec_p0.rw  = 1'b1;
        w_dec_p0.fs  = FS_PASSB;
        w_dec_p0.imm = f_sext32({Instruction[31:12], 12'b0});
      end
      OP_AUIPC: begin
        w_dec_p0.mb  = 1'b1;
        w_dec_p0.mp  = 1'b1;
        w_dec_p0.rw  = 1'b1;
        w_dec_p0.imm = f_sext32({Instruction[31:12], 12'b0});
      end
      OP_JAL: begin
        w_dec_p0.mb  = 1'b1;
        w_dec_p0.mp  = 1'b1;
        w_dec_p0.rw  = 1'b1;
        w_dec_p0.imm = f_sext32({{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                                 Instruction[20], Instruction[30:21], 1'b0});
      end
      OP_JALR: begin
        w_dec_p0.mb  = 1'b1;
        w_dec_p0.rw  = 1'b1;
        w_dec_p0.imm = f_sext32({{20{Instruction[31]}}, Instruction[31:20]});
      end
      OP_BRANCH: begin
        w_dec_p0.fs  = FS_SUB;
        w_dec_p0.imm = f_sext32({{19{Instruction[31]}}, Instruction[31], Instruction[7],
                                 Instruction[30:25], Instruction[11:8], 1'b0});
      end
      OP_LOAD: begin
        w_dec_p0.mb      = 1'b1;
        w_dec_p0.md      = 1'b1;
        w_dec_p0.rw      = 1'b1;
        w_dec_p0.imm     = f_sext32({{20{Instruction[31]}}, Instruction[31:20]});
        w_dec_p0.illegal = w_f3_wide;
      end
      OP_STORE: begin
        w_dec_p0.mb      = 1'b1;
        w_dec_p0.mw      = 1'b1;
        w_dec_p0.imm     = f_sext32({{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]});
        w_dec_p0.strb    = f_strb(Instruction[14:12], w_n);
        w_dec_p0.illegal = w_f3_wide | f_misaligned(Instruction[14:12], w_n);
      end
      OP_IMM: begin
        w_dec_p0.mb  = 1'b1;
        w_dec_p0.rw  = 1'b1;
        w_dec_p0.fs  = f_alu_fs(Instruction[14:12],
                                (Instruction[14:12] == 3'b101) & Instruction[30]);
        w_dec_p0.imm = f_sext32({{20{Instruction[31]}}, Instruction[31:20]});
      end
      OP_REG: begin
        w_dec_p0.rw = 1'b1;
        w_dec_p0.fs = f_alu_fs(Instruction[14:12], Instruction[30]);
      end
      default: w_dec_p0.illegal = 1'b1;
    endcase
    if (Instruction[11:7] == 5'd0) w_dec_p0.rw = 1'b0;
    if (w_dec_p0.illegal) begin
      w_dec_p0.mw   = 1'b0;
      w_dec_p0.rw   = 1'b0;
      w_dec_p0.md   = 1'b0;
      w_dec_p0.strb = '0;
    end
  end

  // ---- stage p1: skid buffer; data cleared on reset so outputs read zero ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_vld_p1   <= 1'b0;
      r_in_ready <= 1'b1;
      r_out_p1   <= '0;
      r_skid_p1  <= '0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_vld_p1   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_out_p1 <= w_dec_p0;
            r_vld_p1 <= 1'b1;
            r_state  <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && !w_retire) begin
            r_skid_p1  <= w_dec_p0;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (w_accept) begin
            r_out_p1 <= w_dec_p0;
          end else if (w_retire) begin
            r_vld_p1 <= 1'b0;
            r_state  <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_retire) begin
            r_out_p1   <= r_skid_p1;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_vld_p1   <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_vld_p1;
  assign illegal   = r_out_p1.illegal;
  assign MW        = r_out_p1.mw;
  assign RW        = r_out_p1.rw;
  assign MD        = r_out_p1.md;
  assign MB        = r_out_p1.mb;
  assign MP        = r_out_p1.mp;
  assign FS        = r_out_p1.fs;
  assign RD        = r_out_p1.rd;
  assign RS1       = r_out_p1.rs1;
  assign RS2       = r_out_p1.rs2;
  assign opcode    = r_out_p1.opcode;
  assign funct3    = r_out_p1.funct3;
  assign STRB      = r_out_p1.strb;
  assign IMM       = r_out_p1.imm;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Testbench for pipelined_instruction_decoder: a 32-bit and a 64-bit
// instance share stimulus; a vector table covers decode, hand-written
// sequences cover backpressure, flush and reset.
module tb_pipelined_instruction_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] Instruction;
  logic [6:0]  Address_mem;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, MW, RW, MD, MB, MP, illegal;
  logic [3:0]  FS;
  logic [4:0]  RD, RS1, RS2;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  STRB;
  logic [31:0] IMM;

  logic        in_ready_w, out_valid_w, MW_w, RW_w, MD_w, MB_w, MP_w, illegal_w;
  logic [3:0]  FS_w;
  logic [4:0]  RD_w, RS1_w, RS2_w;
  logic [6:0]  opcode_w;
  logic [2:0]  funct3_w;
  logic [7:0]  STRB_w;
  logic [63:0] IMM_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_instruction_decoder #(.DATA_W(32), .ADDR_W(7)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Instruction(Instruction), .Address_mem(Address_mem), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .MW(MW), .RW(RW), .MD(MD),
    .MB(MB), .MP(MP), .FS(FS), .RD(RD), .RS1(RS1), .RS2(RS2), .opcode(opcode),
    .funct3(funct3), .STRB(STRB), .IMM(IMM), .illegal(illegal)
  );

  pipelined_instruction_decoder #(.DATA_W(64), .ADDR_W(7)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .Instruction(Instruction), .Address_mem(Address_mem), .flush(flush),
    .out_valid(out_valid_w), .out_ready(out_ready), .MW(MW_w), .RW(RW_w), .MD(MD_w),
    .MB(MB_w), .MP(MP_w), .FS(FS_w), .RD(RD_w), .RS1(RS1_w), .RS2(RS2_w),
    .opcode(opcode_w), .funct3(funct3_w), .STRB(STRB_w), .IMM(IMM_w),
    .illegal(illegal_w)
  );

  typedef struct {
    logic [31:0] ins;
    logic [6:0]  addr;
    logic        ill, mw, rw, md, mb, mp;
    logic [3:0]  fs;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  strb;
    logic [31:0] imm;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ins, input logic [6:0] addr,
                              input logic ill, input logic mw, input logic rw,
                              input logic md, input logic mb, input logic mp,
                              input logic [3:0] fs, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [3:0] strb, input logic [31:0] imm);
    vec_t v;
    v.ins = ins; v.addr = addr; v.ill = ill; v.mw = mw; v.rw = rw; v.md = md;
    v.mb = mb; v.mp = mp; v.fs = fs; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.strb = strb; v.imm = imm;
    return v;
  endfunction

  function automatic logic [70:0] act32();
    return {illegal, MW, RW, MD, MB, MP, FS, RD, RS1, RS2, opcode, funct3, STRB, IMM};
  endfunction

  function automatic logic [70:0] exp32(input vec_t v);
    return {v.ill, v.mw, v.rw, v.md, v.mb, v.mp, v.fs, v.rd, v.rs1, v.rs2,
            v.ins[6:0], v.ins[14:12], v.strb, v.imm};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_A = 32'h00100513;  // ADDI x10,x0,1
  localparam logic [31:0] I_B = 32'h00200593;  // ADDI x11,x0,2
  localparam logic [31:0] I_C = 32'h00300613;  // ADDI x12,x0,3

  vec_t vt[18];

  initial begin
    //       ins           addr   il mw rw md mb mp fs     rd  rs1 rs2 strb     imm
    vt[0]  = mk(32'h002081B3, 7'h00, 0, 0, 1, 0, 0, 0, 4'd0,  3,  1,  2, 4'h0, 32'h0);
    vt[1]  = mk(32'h407302B3, 7'h00, 0, 0, 1, 0, 0, 0, 4'd1,  5,  6,  7, 4'h0, 32'h0);
    vt[2]  = mk(32'hFFF00093, 7'h00, 0, 0, 1, 0, 1, 0, 4'd0,  1,  0, 31, 4'h0, 32'hFFFFFFFF);
    vt[3]  = mk(32'h40315113, 7'h00, 0, 0, 1, 0, 1, 0, 4'd7,  2,  2,  3, 4'h0, 32'h00000403);
    vt[4]  = mk(32'h0080A203, 7'h00, 0, 0, 1, 1, 1, 0, 4'd0,  4,  1,  8, 4'h0, 32'h8);
    vt[5]  = mk(32'h002082A3, 7'h06, 0, 1, 0, 0, 1, 0, 4'd0,  5,  1,  2, 4'b0100, 32'h5);
    vt[6]  = mk(32'h0020A023, 7'h02, 1, 0, 0, 0, 1, 0, 4'd0,  0,  1,  2, 4'h0, 32'h0);
    vt[7]  = mk(32'h00209023, 7'h02, 0, 1, 0, 0, 1, 0, 4'd0,  0,  1,  2, 4'b1100, 32'h0);
    vt[8]  = mk(32'hFE208EE3, 7'h00, 0, 0, 0, 0, 0, 0, 4'd1, 29,  1,  2, 4'h0, 32'hFFFFFFFC);
    vt[9]  = mk(32'h008000EF, 7'h00, 0, 0, 1, 0, 1, 1, 4'd0,  1,  0,  8, 4'h0, 32'h8);
    vt[10] = mk(32'h800002B7, 7'h00, 0, 0, 1, 0, 1, 0, 4'd10, 5,  0,  0, 4'h0, 32'h80000000);
    vt[11] = mk(32'h00001317, 7'h00, 0, 0, 1, 0, 1, 1, 4'd0,  6,  0,  0, 4'h0, 32'h00001000);
    vt[12] = mk(32'h00208033, 7'h00, 0, 0, 0, 0, 0, 0, 4'd0,  0,  1,  2, 4'h0, 32'h0);
    vt[13] = mk(32'h0000008B, 7'h00, 1, 0, 0, 0, 0, 0, 4'd0,  1,  0,  0, 4'h0, 32'h0);
    vt[14] = mk(32'h0000B183, 7'h00, 1, 0, 0, 0, 1, 0, 4'd0,  3,  1,  0, 4'h0, 32'h0);
    vt[15] = mk(32'h009433B3, 7'h00, 0, 0, 1, 0, 0, 0, 4'd4,  7,  8,  9, 4'h0, 32'h0);
    vt[16] = mk(32'h0020B023, 7'h00, 1, 0, 0, 0, 1, 0, 4'd0,  0,  1,  2, 4'h0, 32'h0);
    vt[17] = mk(32'h0020A023, 7'h04, 0, 1, 0, 0, 1, 0, 4'd0,  0,  1,  2, 4'hF, 32'h0);

    rst_n = 1'b0; in_valid = 1'b0; Instruction = '0; Address_mem = '0;
    flush = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_in_ready",  128'(in_ready),  128'(1'b1));
    check("rst_fields",    128'(act32()),   128'(0));
    check("rst_imm64",     128'({IMM_w, STRB_w}), 128'(0));
    rst_n = 1'b1;

    // Streaming decode with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; Instruction = vt[i].ins; Address_mem = vt[i].addr;
      cyc();
      check($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1'b1));
      check($sformatf("vec%0d_fields", i), 128'(act32()), 128'(exp32(vt[i])));
      if (vt[i].ins == 32'h800002B7)
        check("lui64", 128'({IMM_w, FS_w, MB_w}), 128'({64'hFFFFFFFF80000000, 4'd10, 1'b1}));
      if (vt[i].ins == 32'h0020B023)
        check("sd64", 128'({STRB_w, MW_w, illegal_w}), 128'({8'hFF, 1'b1, 1'b0}));
      if (vt[i].ins == 32'h0020A023 && vt[i].addr == 7'h04)
        check("sw64_hi", 128'({STRB_w, MW_w, illegal_w}), 128'({8'hF0, 1'b1, 1'b0}));
    end
    in_valid = 1'b0;
    cyc();
    check("drain_empty", 128'(out_valid), 128'(1'b0));

    // Backpressure: three offered, two held, then released in order
    out_ready = 1'b0; in_valid = 1'b1; Instruction = I_A; Address_mem = '0;
    cyc();
    check("bp_first", 128'({out_valid, in_ready, RD}), 128'({1'b1, 1'b1, 5'd10}));
    Instruction = I_B;
    cyc();
    check("bp_ready_low", 128'(in_ready), 128'(1'b0));
    Instruction = I_C;
    cyc();
    check("bp_hold", 128'({out_valid, in_ready, RD, IMM}), 128'({1'b1, 1'b0, 5'd10, 32'd1}));
    out_ready = 1'b1;
    cyc();
    check("bp_second", 128'({out_valid, in_ready, RD, IMM}), 128'({1'b1, 1'b1, 5'd11, 32'd2}));
    cyc();
    check("bp_third", 128'({out_valid, RD, IMM}), 128'({1'b1, 5'd12, 32'd3}));
    in_valid = 1'b0;
    cyc();
    check("bp_done", 128'(out_valid), 128'(1'b0));

    // Flush while full, with a new instruction offered
    out_ready = 1'b0; in_valid = 1'b1; Instruction = I_A;
    cyc();
    Instruction = I_B;
    cyc();
    check("fl_full", 128'(in_ready), 128'(1'b0));
    flush = 1'b1; Instruction = I_C;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_after", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("fl_gone%0d", k), 128'(out_valid), 128'(1'b0));
    end

    // Flush in ONE drops the entry accepted on the same edge
    in_valid = 1'b1; Instruction = I_A;
    cyc();
    flush = 1'b1; Instruction = I_B;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_one", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    cyc();
    check("fl_one_gone", 128'(out_valid), 128'(1'b0));

    // Reset while in ONE
    out_ready = 1'b0; in_valid = 1'b1; Instruction = I_C;
    cyc();
    check("rs1_loaded", 128'({out_valid, RD}), 128'({1'b1, 5'd12}));
    in_valid = 1'b0; rst_n = 1'b0;
    cyc();
    check("rs1_state", 128'({out_valid, in_ready, out_valid_w}), 128'({1'b0, 1'b1, 1'b0}));
    check("rs1_fields", 128'(act32()), 128'(0));
    check("rs1_fields64", 128'({IMM_w, STRB_w, RD_w, opcode_w}), 128'(0));
    rst_n = 1'b1; out_ready = 1'b1;
    cyc();
    check("rs1_gone", 128'(out_valid), 128'(1'b0));

    // Reset while in TWO discards both entries
    out_ready = 1'b0; in_valid = 1'b1; Instruction = I_A;
    cyc();
    Instruction = I_B;
    cyc();
    check("rs2_full", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("rs2_gone%0d", k), 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
